// File: rtl/ft60x_fifo_bridge_if.sv
// rtl/ft60x_fifo_bridge_if.sv - strobe and stream handshake bundle for the FT60x FIFO bridge
interface ft60x_fifo_bridge_if #(
    parameter int DATA_W = 32
) ();
    localparam int BE_W = DATA_W / 8;

    // chip-side flags and strobes
    logic              usb_txe_l;
    logic              usb_rxf_l;
    logic              usb_wren_l;
    logic              usb_rden_l;
    logic              usb_outen_l;
    logic              usb_rst_l;

    // host-to-device stream out of the skid FIFO
    logic [DATA_W-1:0] rx_data;
    logic [BE_W-1:0]   rx_be;
    logic              rx_valid;
    logic              rx_ready;

    // device-to-host stream into the chip
    logic [DATA_W-1:0] tx_data;
    logic [BE_W-1:0]   tx_be;
    logic              tx_valid;
    logic              tx_ready;

    logic              busy_rx;
    logic              busy_tx;

    modport master (
        input  usb_txe_l, usb_rxf_l, rx_ready, tx_data, tx_be, tx_valid,
        output usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l,
               rx_data, rx_be, rx_valid, tx_ready, busy_rx, busy_tx
    );

    modport slave (
        output usb_txe_l, usb_rxf_l, rx_ready, tx_data, tx_be, tx_valid,
        input  usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l,
               rx_data, rx_be, rx_valid, tx_ready, busy_rx, busy_tx
    );
endinterface

// File: rtl/ft60x_fifo_bridge.sv
// rtl/ft60x_fifo_bridge.sv - FT600/FT601 synchronous 245-FIFO bridge with RX skid FIFO
module ft60x_fifo_bridge #(
    parameter int DATA_W     = 32,
    parameter int RX_DEPTH   = 8,
    parameter int MAX_BURST  = 64,
    parameter int RST_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    inout  wire  [DATA_W-1:0]   usb_data,
    inout  wire  [DATA_W/8-1:0] usb_be,
    ft60x_fifo_bridge_if.master bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int WW   = DATA_W + BE_W;
    localparam int AW   = $clog2(RX_DEPTH);
    localparam int CW   = AW + 1;
    localparam int BW   = $clog2(MAX_BURST + 1);
    localparam int RW   = $clog2(RST_CYCLES + 1);

    localparam logic [CW-1:0] C_DEPTH = CW'(RX_DEPTH);
    localparam logic [CW-1:0] C_TWO   = CW'(2);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [BW-1:0] C_MAXB  = BW'(MAX_BURST);
    localparam logic [RW-1:0] C_RLAST = RW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RST_WAIT,
        ST_IDLE,
        ST_RX_TURN,
        ST_RX,
        ST_TX
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [RW-1:0]   r_rst_cnt;
    logic            r_last_rx;
    logic [BW-1:0]   r_burst;
    logic            r_rden_l;

    logic [WW-1:0]   r_mem [RX_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_tx_accept;
    logic            w_rx_req;
    logic            w_tx_req;
    logic            w_drive;
    logic [CW-1:0]   w_count_next;
    logic [CW-1:0]   w_free;
    logic [CW-1:0]   w_free_next;
    logic [BW-1:0]   w_burst_next;
    logic [WW-1:0]   w_head;

    // Capture happens only on edges where our read strobe meets chip data.
    assign w_push       = (r_state == ST_RX) && !r_rden_l && !bus.usb_rxf_l;
    assign w_pop        = (r_count != '0) && bus.rx_ready;
    assign w_tx_accept  = (r_state == ST_TX) && bus.tx_valid && !bus.usb_txe_l;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_free       = C_DEPTH - r_count;
    assign w_free_next  = C_DEPTH - w_count_next;
    assign w_burst_next = r_burst + BW'(w_push | w_tx_accept);
    assign w_rx_req     = !bus.usb_rxf_l && (w_free >= C_TWO);
    assign w_tx_req     = !bus.usb_txe_l && bus.tx_valid;
    assign w_drive      = (r_state == ST_TX);
    assign w_head       = r_mem[r_rd_ptr];

    assign usb_data = w_drive ? bus.tx_data : {DATA_W{1'bz}};
    assign usb_be   = w_drive ? bus.tx_be   : {BE_W{1'bz}};

    assign bus.usb_rst_l   = (r_state != ST_RST_WAIT);
    assign bus.usb_outen_l = !((r_state == ST_RX_TURN) || (r_state == ST_RX));
    assign bus.usb_rden_l  = r_rden_l;
    assign bus.usb_wren_l  = !w_tx_accept;
    assign bus.tx_ready    = w_tx_accept;
    assign bus.busy_rx     = (r_state == ST_RX_TURN) || (r_state == ST_RX);
    assign bus.busy_tx     = (r_state == ST_TX);
    assign bus.rx_valid    = (r_count != '0);
    assign bus.rx_data     = w_head[DATA_W-1:0];
    assign bus.rx_be       = w_head[WW-1:DATA_W];

    // Next-state: reset wait, round-robin arbitration, and burst exit rules.
    // Exits look at this edge's capture/accept so a burst never overshoots
    // MAX_BURST and the FIFO keeps one slot of slack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RST_WAIT: begin
                if (r_rst_cnt == C_RLAST) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_rx_req && w_tx_req) begin
                    w_state_next = r_last_rx ? ST_TX : ST_RX_TURN;
                end else if (w_rx_req) begin
                    w_state_next = ST_RX_TURN;
                end else if (w_tx_req) begin
                    w_state_next = ST_TX;
                end
            end
            ST_RX_TURN: begin
                w_state_next = ST_RX;
            end
            ST_RX: begin
                if (bus.usb_rxf_l || (w_burst_next >= C_MAXB) || (w_free_next <= C_ONE)) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_TX: begin
                if (bus.usb_txe_l || !bus.tx_valid || (w_burst_next >= C_MAXB)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_RST_WAIT;
            end
        endcase
    end

    // State register and chip reset pulse counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RST_WAIT;
            r_rst_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_RST_WAIT) begin
                r_rst_cnt <= r_rst_cnt + RW'(1);
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    // Direction memory and burst counter; both restart on entry to a direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_rx <= 1'b0;
            r_burst   <= '0;
        end else if ((r_state == ST_IDLE) && (w_state_next == ST_RX_TURN)) begin
            r_last_rx <= 1'b1;
            r_burst   <= '0;
        end else if ((r_state == ST_IDLE) && (w_state_next == ST_TX)) begin
            r_last_rx <= 1'b0;
            r_burst   <= '0;
        end else begin
            r_burst <= w_burst_next;
        end
    end

    // Registered read strobe: only asserted when the FIFO can still take a word next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rden_l <= 1'b1;
        end else begin
            r_rden_l <= !((w_state_next == ST_RX) && (w_free_next >= C_TWO));
        end
    end

    // Skid FIFO pointers and occupancy; pointers wrap on the power-of-two depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Skid FIFO storage; contents are don't-care while empty so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {usb_be, usb_data};
        end
    end
endmodule

// File: tb/tb_ft60x_fifo_bridge.sv
// tb/tb_ft60x_fifo_bridge.sv - self-checking bench for ft60x_fifo_bridge
module tb_ft60x_fifo_bridge;
    localparam int DATA_W     = 32;
    localparam int BE_W       = DATA_W / 8;
    localparam int WW         = DATA_W + BE_W;
    localparam int RX_DEPTH   = 8;
    localparam int MAX_BURST  = 64;
    localparam int RST_CYCLES = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wire [DATA_W-1:0] usb_data;
    wire [BE_W-1:0]   usb_be;

    ft60x_fifo_bridge_if #(.DATA_W(DATA_W)) bus ();

    ft60x_fifo_bridge #(
        .DATA_W    (DATA_W),
        .RX_DEPTH  (RX_DEPTH),
        .MAX_BURST (MAX_BURST),
        .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .usb_data(usb_data),
        .usb_be  (usb_be),
        .bus     (bus)
    );

    // chip model: drives its RX head word whenever the FPGA enables chip output
    logic [WW-1:0]     chip_q [$];
    logic              chip_txe_l = 1'b1;
    logic [DATA_W-1:0] chip_d = '0;
    logic [BE_W-1:0]   chip_b = '0;
    assign usb_data = bus.usb_outen_l ? {DATA_W{1'bz}} : chip_d;
    assign usb_be   = bus.usb_outen_l ? {BE_W{1'bz}}   : chip_b;

    // producer, model FIFO contents and logs
    logic [WW-1:0] tx_src [$];
    logic [WW-1:0] mq [$];
    logic [WW-1:0] rx_log [$];
    logic [WW-1:0] tx_log [$];
    logic [WW-1:0] sent [$];
    int            runs [$];
    int            tx_idx  = 0;
    logic          tx_en   = 1'b0;
    int            tx_run  = 0;
    int            rx_run  = 0;
    int            gap     = 0;
    logic          saw_tx  = 1'b0;
    int            rel_cnt = 0;

    logic s_rst_l, s_wren_l, s_rden_l, s_outen_l, s_tx_ready, s_busy_rx, s_busy_tx, s_rx_valid;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.usb_rxf_l = (chip_q.size() == 0);
        bus.usb_txe_l = chip_txe_l;
        if (chip_q.size() != 0) {chip_b, chip_d} = chip_q[0];
        else                    {chip_b, chip_d} = '0;
        bus.tx_valid = tx_en && (tx_idx < tx_src.size());
        if (tx_idx < tx_src.size()) {bus.tx_be, bus.tx_data} = tx_src[tx_idx];
        else                        {bus.tx_be, bus.tx_data} = '0;
    endtask

    // per-cycle comparison against the model, sampled at the falling edge
    task automatic sample_and_check();
        s_rst_l    = bus.usb_rst_l;
        s_wren_l   = bus.usb_wren_l;
        s_rden_l   = bus.usb_rden_l;
        s_outen_l  = bus.usb_outen_l;
        s_tx_ready = bus.tx_ready;
        s_busy_rx  = bus.busy_rx;
        s_busy_tx  = bus.busy_tx;
        s_rx_valid = bus.rx_valid;
        chk("rx_valid", s_rx_valid, mq.size() != 0);
        if (mq.size() != 0) chk("rx_head", {bus.rx_be, bus.rx_data}, mq[0]);
        chk("tx_ready", s_tx_ready, !s_wren_l);
        chk("strobe_excl", s_wren_l | s_outen_l, 1);
        chk("rden_outen", s_rden_l | !s_outen_l, 1);
        chk("usb_rst_l", s_rst_l, !rst && (rel_cnt >= RST_CYCLES));
        chk("fifo_bound", mq.size() <= RX_DEPTH, 1);
        if (!s_wren_l && (tx_idx < tx_src.size())) chk("tx_bus", {usb_be, usb_data}, tx_src[tx_idx]);
        if (!s_busy_tx && (tx_run > 0)) begin
            chk("tx_burst_cap", tx_run <= MAX_BURST, 1);
            runs.push_back(tx_run);
            tx_run = 0;
        end
        if (!s_busy_rx && (rx_run > 0)) begin
            chk("rx_burst_cap", rx_run <= MAX_BURST, 1);
            runs.push_back(1000 + rx_run);
            rx_run = 0;
        end
        if (s_busy_tx) begin
            saw_tx = 1'b1;
            gap    = 0;
        end else if (s_outen_l) begin
            gap++;
        end else if (saw_tx) begin
            chk("turnaround_gap", gap >= 1, 1);
            saw_tx = 1'b0;
        end
    endtask

    task automatic tick();
        logic          rd_fire;
        logic          wr_fire;
        logic          pop_fire;
        logic [WW-1:0] w;
        @(negedge clk);
        sample_and_check();
        rd_fire  = !s_rden_l && !bus.usb_rxf_l;
        wr_fire  = !s_wren_l && !bus.usb_txe_l;
        pop_fire = s_rx_valid && bus.rx_ready;
        w        = {usb_be, usb_data};
        if (rd_fire) rx_run++;
        if (wr_fire) tx_run++;
        @(posedge clk);
        #1;
        if (rst) rel_cnt = 0;
        else     rel_cnt++;
        if (pop_fire) rx_log.push_back(mq.pop_front());
        if (rd_fire)  mq.push_back(chip_q.pop_front());
        if (wr_fire) begin
            tx_log.push_back(w);
            tx_idx++;
        end
        drive();
    endtask

    task automatic count_rst_low(input string name);
        int lows;
        int bad;
        lows = 0;
        bad  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (s_rst_l) break;
            lows++;
            if (!(s_wren_l && s_rden_l && s_outen_l) || s_busy_tx || s_busy_rx) bad++;
        end
        chk({name, "_low_cycles"}, lows, RST_CYCLES);
        chk({name, "_strobes_idle"}, bad, 0);
    endtask

    logic [WW-1:0] exp2 [5];
    logic [WW-1:0] w;
    int            errs;
    int            turn;

    initial begin
        exp2[0] = 36'hF_1111_1111;
        exp2[1] = 36'hF_2222_2222;
        exp2[2] = 36'hF_3333_3333;
        exp2[3] = 36'hF_4444_4444;
        exp2[4] = 36'hF_5555_5555;
        bus.rx_ready = 1'b0;
        drive();

        // reset state
        repeat (2) tick();
        chk("rst_wren_l", s_wren_l, 1);
        chk("rst_rden_l", s_rden_l, 1);
        chk("rst_outen_l", s_outen_l, 1);
        chk("rst_usb_rst_l", s_rst_l, 0);
        chk("rst_rx_valid", s_rx_valid, 0);
        chk("rst_tx_ready", s_tx_ready, 0);
        chk("rst_busy_rx", s_busy_rx, 0);
        chk("rst_busy_tx", s_busy_tx, 0);

        // chip reset pulse after release
        rst = 1'b0;
        count_rst_low("rst_release");

        // five-word RX burst with a ready consumer
        runs.delete();
        rx_log.delete();
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) chip_q.push_back(exp2[i]);
        drive();
        turn = 0;
        for (int i = 0; i < 100 && !((rx_log.size() == 5) && !s_busy_rx); i++) begin
            tick();
            if (!s_outen_l && s_rden_l) turn++;
        end
        repeat (2) tick();
        chk("rx5_turn_cycles", turn, 1);
        chk("rx5_count", rx_log.size(), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("rx5_word%0d", i), (i < rx_log.size()) ? rx_log[i] : '0, exp2[i]);
        chk("rx5_runs", runs.size(), 1);
        chk("rx5_run_len", (runs.size() > 0) ? runs[0] : 0, 1005);
        chk("rx5_idle", s_busy_rx, 0);

        // back-pressure: 20 words offered, consumer stalled
        runs.delete();
        rx_log.delete();
        sent.delete();
        bus.rx_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            w = {((i % 2) != 0) ? 4'h3 : 4'hC, 32'h0000_1000 + 32'(i)};
            chip_q.push_back(w);
            sent.push_back(w);
        end
        drive();
        repeat (40) tick();
        chk("bp_buffered", mq.size(), 7);
        chk("bp_chip_left", chip_q.size(), 13);
        chk("bp_rx_valid", s_rx_valid, 1);
        chk("bp_rden_high", s_rden_l, 1);
        chk("bp_idle", s_busy_rx, 0);
        bus.rx_ready = 1'b1;
        for (int i = 0; i < 400 && rx_log.size() < 20; i++) tick();
        repeat (4) tick();
        chk("bp_drained", rx_log.size(), 20);
        errs = 0;
        for (int i = 0; i < 20; i++)
            if (i >= rx_log.size() || rx_log[i] !== sent[i]) errs++;
        chk("bp_order", errs, 0);

        // TX burst cap with competing RX
        runs.delete();
        rx_log.delete();
        tx_log.delete();
        tx_src.delete();
        tx_idx = 0;
        for (int i = 0; i < 100; i++) tx_src.push_back({4'hF, 32'hA000_0000 + 32'(i)});
        for (int i = 0; i < 10; i++)  chip_q.push_back({4'h5, 32'hB000_0000 + 32'(i)});
        chip_txe_l = 1'b0;
        tx_en      = 1'b1;
        drive();
        for (int i = 0; i < 600 && (tx_log.size() < 100 || rx_log.size() < 10 || s_busy_tx || s_busy_rx); i++) tick();
        repeat (3) tick();
        chk("arb_runs", runs.size(), 3);
        chk("arb_run0_tx", (runs.size() > 0) ? runs[0] : 0, 64);
        chk("arb_run1_rx", (runs.size() > 1) ? runs[1] : 0, 1010);
        chk("arb_run2_tx", (runs.size() > 2) ? runs[2] : 0, 36);
        chk("arb_tx_count", tx_log.size(), 100);
        errs = 0;
        for (int i = 0; i < 100; i++)
            if (i >= tx_log.size() || tx_log[i] !== tx_src[i]) errs++;
        chk("arb_tx_order", errs, 0);
        errs = 0;
        for (int i = 0; i < 10; i++)
            if (i >= rx_log.size() || rx_log[i] !== {4'h5, 32'hB000_0000 + 32'(i)}) errs++;
        chk("arb_rx_order", errs, 0);

        // txe_l pause mid-burst
        runs.delete();
        tx_log.delete();
        tx_src.delete();
        tx_idx = 0;
        for (int i = 0; i < 20; i++) tx_src.push_back({4'h3, 32'hC000_0000 + 32'(i)});
        drive();
        for (int i = 0; i < 100 && tx_log.size() < 8; i++) tick();
        chip_txe_l = 1'b1;
        drive();
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("pause_wren_l", s_wren_l, 1);
            chk("pause_tx_ready", s_tx_ready, 0);
        end
        chk("pause_words", tx_log.size(), 8);
        chip_txe_l = 1'b0;
        drive();
        for (int i = 0; i < 200 && (tx_log.size() < 20 || s_busy_tx); i++) tick();
        chk("pause_total", tx_log.size(), 20);
        errs = 0;
        for (int i = 0; i < 20; i++)
            if (i >= tx_log.size() || tx_log[i] !== tx_src[i]) errs++;
        chk("pause_order", errs, 0);
        tx_en = 1'b0;
        drive();

        // reset asserted in the middle of an RX burst
        runs.delete();
        rx_log.delete();
        for (int i = 0; i < 30; i++) chip_q.push_back({4'hA, 32'hD000_0000 + 32'(i)});
        drive();
        for (int i = 0; i < 100 && rx_log.size() < 3; i++) tick();
        chk("mid_busy_rx", s_busy_rx, 1);
        chk("mid_rden_low", bus.usb_rden_l, 0);
        rst = 1'b1;
        #1;
        chk("arst_rden_l", bus.usb_rden_l, 1);
        chk("arst_outen_l", bus.usb_outen_l, 1);
        chk("arst_wren_l", bus.usb_wren_l, 1);
        chk("arst_usb_rst_l", bus.usb_rst_l, 0);
        chk("arst_busy_rx", bus.busy_rx, 0);
        mq.delete();
        chip_q.delete();
        drive();
        repeat (2) tick();
        chk("arst_rx_valid", s_rx_valid, 0);
        rst = 1'b0;
        count_rst_low("rst_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ft60x_fifo_bridge.md
Name: ft60x_fifo_bridge

Overview:
Parametrised synchronous 245-FIFO bridge for FT600 (16-bit) and FT601 (32-bit) parts, sitting between the USB chip pins and the peripheral arbiter.
- Arbitrates between host-to-device (RX) and device-to-host (TX) bursts using round-robin with a burst cap.
- Buffers RX words in an internal skid FIFO behind a valid/ready interface, so back-pressure never drops bus data.
- Sequences the chip reset pulse and bus turnaround.

Parameters:
DATA_W, 32, USB data bus width; legal values 16 or 32; BE_W = DATA_W/8.
RX_DEPTH, 8, RX skid FIFO depth in words; power of 2, minimum 4.
MAX_BURST, 64, maximum words per direction before re-arbitration; minimum 1.
RST_CYCLES, 16, clk cycles usb_rst_l is held low after rst deasserts.

Ports:
clk  in  1  single system clock (FT60x CLKOUT domain)
rst  in  1  asynchronous, active-high reset
usb_txe_l  in  1  low = chip TX FIFO has space
usb_rxf_l  in  1  low = chip RX FIFO has data
usb_wren_l  out  1  write strobe, active low
usb_rden_l  out  1  read strobe, active low
usb_outen_l  out  1  chip output enable, active low
usb_rst_l  out  1  chip reset, active low
usb_data  inout  DATA_W  chip data bus
usb_be  inout  BE_W  chip byte enables
rx_data  out  DATA_W  received word (FIFO head)
rx_be  out  BE_W  byte enables of rx_data
rx_valid  out  1  rx_data/rx_be valid
rx_ready  in  1  consumer accepts head word
tx_data  in  DATA_W  word to send
tx_be  in  BE_W  byte enables to send
tx_valid  in  1  tx word available
tx_ready  out  1  tx word consumed this cycle
busy_rx  out  1  state is RX_TURN or RX
busy_tx  out  1  state is TX

Behaviour:
- Reset values: usb_wren_l=1, usb_rden_l=1, usb_outen_l=1, usb_rst_l=0, rx_valid=0, tx_ready=0, busy_*=0, FIFO empty, state=RST_WAIT, last_dir=TX, burst count=0. FPGA releases usb_data/usb_be (high-Z).
- RST_WAIT: counts RST_CYCLES clk cycles after rst deasserts, holding usb_rst_l=0. On count done: usb_rst_l=1 and state goes to IDLE.
- IDLE: all strobes high, bus high-Z.
  - rx_req = !usb_rxf_l && FIFO free >= 2.
  - tx_req = !usb_txe_l && tx_valid.
  - Both requests: go to the direction opposite last_dir. One request: go to that direction. Neither: stay.
  - RX target is RX_TURN; TX target is TX.
- RX_TURN: one cycle with usb_outen_l=0 and usb_rden_l=1 (bus turnaround). Then go to RX.
- RX: usb_outen_l=0. usb_rden_l is registered: it is low in a cycle iff, at the previous edge, state was entering or in RX and the projected FIFO free count was >= 2.
  - Capture: on each edge where usb_rden_l=0 and usb_rxf_l=0, push {usb_be, usb_data} into the FIFO and increment the burst count.
  - Exit to IDLE when any of these holds: usb_rxf_l=1; burst count reaches MAX_BURST; FIFO free <= 1.
  - On exit, usb_outen_l and usb_rden_l return high on the same edge.
  - FIFO overflow is impossible by construction.
- TX: the FPGA drives usb_data=tx_data and usb_be=tx_be for the whole state.
  - usb_wren_l = !(tx_valid && !usb_txe_l), combinational; tx_ready equals !usb_wren_l.
  - Each accepted word increments the burst count.
  - Exit to IDLE when any of these holds: usb_txe_l=1; tx_valid=0; burst count reaches MAX_BURST.
  - Bus goes high-Z in IDLE, giving at least one turnaround cycle before usb_outen_l can fall.
- On entry to any direction: last_dir is updated and the burst count cleared.
- RX FIFO: rx_valid = !empty; rx_data/rx_be come from the head (first-word-fall-through). Pop on rx_valid && rx_ready.
  - Simultaneous push and pop is allowed and leaves the count unchanged.
  - Pointers wrap modulo RX_DEPTH.
- rst asserted mid-burst: all strobes go high immediately (async), the bus goes high-Z, and the FIFO is flushed. The RST_WAIT sequence reruns after release.
- 16-bit build: usb_be is 2 bits; there are no width-dependent behaviour differences.

Test Plan:
- Reset release with RST_CYCLES=16 -> usb_rst_l low for exactly 16 cycles after rst falls; strobes high throughout; no bus drive.
- Chip presents 5 words (0x11111111..0x55555555, be=0xF), rx_ready=1 -> one RX_TURN cycle, then 5 captures in order on rx_data, then IDLE when usb_rxf_l rises.
- rx_ready=0, chip offers 20 words, RX_DEPTH=8 -> usb_rden_l rises at free<=1; exactly 7 words buffered, none lost. After draining, the remainder arrives in order.
- tx_valid held with 100 words, usb_txe_l=0, MAX_BURST=64, usb_rxf_l=0 -> 64 TX words, then an RX burst, then the remaining 36 TX words; bus high-Z for at least 1 cycle between directions.
- usb_txe_l pulses high for 3 cycles mid-TX -> usb_wren_l high in those cycles, tx_ready=0, no word consumed or duplicated.
- rst asserted mid-RX burst -> strobes high same cycle, rx_valid=0 after reset, RST_WAIT restarts.
